// File: rtl/dual_index_encoder.sv
// Collects up to two bit indices per cycle into a pending vector and hands it
// to a single-entry registered output stage on flush.
module dual_index_encoder #(
    parameter int N = 8,
    localparam int W = $clog2(N),
    localparam int C = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] dir_a,
    input  logic         en_a,
    input  logic [W-1:0] dir_b,
    input  logic         en_b,
    input  logic         flush,
    output logic         flush_ready,
    output logic [N-1:0] out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [C-1:0] out_count,
    output logic         dup,
    output logic         range_err
);

    // Handshake: out is offered while out_valid=1 and is consumed on the rising
    // edge where out_valid && out_ready; out holds steady until then. A flush is
    // taken on the edge where flush && flush_ready.
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    localparam logic [W:0] N_LIM = (W + 1)'(N);

    logic [0:0]   state_q, state_d;
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] out_q, out_d;
    logic [C-1:0] cnt_q, cnt_d;
    logic         dup_q, dup_d;
    logic         rerr_q, rerr_d;

    logic         ok_a, ok_b;
    logic [N-1:0] mask_a, mask_b, set_mask, merged;
    logic [C-1:0] merged_cnt;
    logic         xfer;

    assign ok_a     = ({1'b0, dir_a} < N_LIM);
    assign ok_b     = ({1'b0, dir_b} < N_LIM);
    assign mask_a   = (en_a && ok_a) ? (N'(1) << dir_a) : '0;
    assign mask_b   = (en_b && ok_b) ? (N'(1) << dir_b) : '0;
    assign set_mask = mask_a | mask_b;
    assign merged   = acc_q | set_mask;

    assign out_valid   = (state_q == FULL);
    assign flush_ready = !out_valid || out_ready;
    assign xfer        = flush && flush_ready;

    always_comb begin
        merged_cnt = '0;
        for (int i = 0; i < N; i++) begin
            merged_cnt = merged_cnt + C'(merged[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = merged;
        out_d   = out_q;
        cnt_d   = cnt_q;
        dup_d   = (en_a && en_b && (dir_a == dir_b)) || |(set_mask & acc_q);
        rerr_d  = (en_a && !ok_a) || (en_b && !ok_b);
        if (xfer) begin
            // Same-cycle writes ride along with the vector being flushed.
            out_d   = merged;
            cnt_d   = merged_cnt;
            acc_d   = '0;
            state_d = FULL;
        end else if (out_valid && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            dup_q   <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            dup_q   <= dup_d;
            rerr_q  <= rerr_d;
        end
    end

    assign out       = out_q;
    assign out_count = cnt_q;
    assign dup       = dup_q;
    assign range_err = rerr_q;

endmodule
